// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter; done pulses BIN_WIDTH+1 edges after start is taken.
// start is ignored while busy; defining BIN_TO_BCD_BLANK_EN adds per-digit leading-zero blanking.
module bin_to_bcd_converter #(
    parameter int BIN_WIDTH = 24,
    parameter int DIGITS    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank_out
);

    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_WIDTH);
    localparam logic [SW-1:0] NINES = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BIN_WIDTH-1:0] shreg;
    logic [SW-1:0]        scratch;
    logic [SW-1:0]        adjusted;
    logic [SW-1:0]        scratch_next;
    logic [SW-1:0]        result_bcd;
    logic [CW-1:0]        cnt;
    logic                 ovf_acc;
    logic                 ovf_next;
    logic                 last;

    assign last = (cnt == CW'(BIN_WIDTH - 1));
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Correct each digit before the shift; the bit leaving the top digit is the overflow carry.
    always_comb begin
        adjusted = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        scratch_next = {adjusted[SW-2:0], shreg[BIN_WIDTH-1]};
        ovf_next     = ovf_acc | adjusted[SW-1];
        result_bcd   = ovf_next ? NINES : scratch_next;
    end

    // Results are captured on the final shift so they are already valid while done is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                    end
                end
                SHIFT: begin
                    shreg   <= {shreg[BIN_WIDTH-2:0], 1'b0};
                    scratch <= scratch_next;
                    ovf_acc <= ovf_next;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        bcd_out  <= result_bcd;
                        overflow <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIN_TO_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic              zero_run;

    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run      = zero_run & (scratch_next[4*i +: 4] == 4'd0);
            blank_next[i] = zero_run & ~ovf_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blank_out <= '0;
        end else if (state == SHIFT && last) begin
            blank_out <= blank_next;
        end
    end
`else
    assign blank_out = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter: default instance plus an 8-bit/2-digit instance,
// results checked against a division-based reference through per-instance scoreboards.
module tb_bin_to_bcd_converter;

    typedef struct packed {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  blank;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;
    logic [7:0]  blank_out;

    logic        start8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        done8;
    logic [7:0]  bcd8;
    logic        overflow8;
    logic [1:0]  blank8;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t q8[$];
    logic done_prev  = 1'b0;
    logic done8_prev = 1'b0;

    always #5 clk = ~clk;

    bin_to_bcd_converter dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out),
        .overflow(overflow), .blank_out(blank_out)
    );

    bin_to_bcd_converter #(.BIN_WIDTH(8), .DIGITS(2)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .bin_in(bin8),
        .busy(busy8), .done(done8), .bcd_out(bcd8),
        .overflow(overflow8), .blank_out(blank8)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference by repeated division, independent of the shift-add structure.
    function automatic exp_t model(input logic [31:0] v, input int nd);
        exp_t        e;
        logic [31:0] t;
        logic        z;
        e = '0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        e.ovf = (t != 0);
        if (e.ovf) begin
            for (int i = 0; i < nd; i++) e.bcd[4*i +: 4] = 4'd9;
        end
`ifdef BIN_TO_BCD_BLANK_EN
        z = 1'b1;
        if (!e.ovf) begin
            for (int i = nd - 1; i >= 1; i--) begin
                if (e.bcd[4*i +: 4] != 4'd0) z = 1'b0;
                e.blank[i] = z;
            end
        end
`else
        z = 1'b0;
        e.blank = {10{z}};
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            check_val("done_width", 64'(done_prev), 64'(0));
            check_val("extra_done", 64'(q.size() > 0), 64'(1));
            if (q.size() > 0) begin
                e = q.pop_front();
                check_val("bcd_out", 64'(bcd_out), 64'(e.bcd));
                check_val("overflow", 64'(overflow), 64'(e.ovf));
                check_val("blank_out", 64'(blank_out), 64'(e.blank));
            end
        end
        done_prev = done & ~reset;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && done8) begin
            check_val("done8_width", 64'(done8_prev), 64'(0));
            check_val("extra_done8", 64'(q8.size() > 0), 64'(1));
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check_val("bcd8", 64'(bcd8), 64'(e.bcd));
                check_val("overflow8", 64'(overflow8), 64'(e.ovf));
                check_val("blank8", 64'(blank8), 64'(e.blank));
            end
        end
        done8_prev = done8 & ~reset;
    end

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_val("done_timeout", 64'(lat > 0), 64'(1));
    endtask

    task automatic wait_done8();
        int lat;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_val("done8_timeout", 64'(lat > 0), 64'(1));
    endtask

    task automatic conv(input logic [23:0] v);
        int lat;
        @(posedge clk); #1;
        bin_in = v;
        start  = 1'b1;
        q.push_back(model(32'(v), 8));
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done(lat);
    endtask

    task automatic conv8(input logic [7:0] v);
        @(posedge clk); #1;
        bin8   = v;
        start8 = 1'b1;
        q8.push_back(model(32'(v), 2));
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done8();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int low;
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        start8 = 1'b0;
        bin8   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
        check_val("rst_bcd", 64'(bcd_out), 64'(0));
        check_val("rst_ovf", 64'(overflow), 64'(0));
        check_val("rst_blank", 64'(blank_out), 64'(0));
        check_val("rst_busy8", 64'(busy8), 64'(0));
        reset = 1'b0;

        // Zero input and latency measured in rising edges from the accepting edge.
        @(posedge clk); #1;
        bin_in = 24'd0;
        start  = 1'b1;
        q.push_back(model(32'd0, 8));
        @(posedge clk); #1;
        start = 1'b0;
        check_val("busy_running", 64'(busy), 64'(1));
        wait_done(lat);
        check_val("latency", 64'(lat), 64'(25));
        @(posedge clk); #1;
        check_val("busy_after_done", 64'(busy), 64'(0));

        // Back-to-back with start held high; bin_in changes while busy must be ignored.
        @(posedge clk); #1;
        bin_in = 24'd12345678;
        start  = 1'b1;
        q.push_back(model(32'd12345678, 8));
        @(posedge clk); #1;
        bin_in = 24'd999999;
        wait_done(lat);
        bin_in = 24'd16777215;
        q.push_back(model(32'd16777215, 8));
        low = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) break;
            low++;
        end
        start = 1'b0;
        check_val("busy_gap", 64'(low), 64'(1));
        wait_done(lat);

        // Re-pulsed start mid-conversion has no effect.
        @(posedge clk); #1;
        bin_in = 24'd999;
        start  = 1'b1;
        q.push_back(model(32'd999, 8));
        @(posedge clk); #1;
        start  = 1'b0;
        bin_in = 24'd0;
        repeat (9) @(posedge clk);
        #1;
        bin_in = 24'd5;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        repeat (40) @(posedge clk);
        #1;
        check_val("idle_after_ignored", 64'(busy), 64'(0));

        // Reset mid-conversion discards the partial result.
        @(posedge clk); #1;
        bin_in = 24'd1234;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_busy", 64'(busy), 64'(0));
        check_val("midrst_done", 64'(done), 64'(0));
        check_val("midrst_bcd", 64'(bcd_out), 64'(0));
        check_val("midrst_ovf", 64'(overflow), 64'(0));
        check_val("midrst_blank", 64'(blank_out), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        conv(24'd42);

        // Blanking patterns and a spread of values.
        conv(24'd405);
        conv(24'd0);
        conv(24'd10000000);
        for (int n = 0; n < 4; n++) conv(24'($urandom_range(0, 24'hFFFFFF)));

        // Narrow instance: overflow saturation and per-conversion clearing.
        conv8(8'd255);
        conv8(8'd99);
        conv8(8'd100);
        conv8(8'd7);
        conv8(8'd0);

        repeat (5) @(posedge clk);
        #1;
        check_val("queue_empty", 64'(q.size()), 64'(0));
        check_val("queue8_empty", 64'(q8.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_converter.md
BIN_TO_BCD_CONVERTER -- requirements
Module: bin_to_bcd_converter

Interface
REQ-001 The block SHALL have parameter BIN_WIDTH, default 24, the binary input width in bits (legal 4..32).
REQ-002 The block SHALL have parameter DIGITS, default 8, the number of BCD output digits (legal 1..10).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit, conversion request, sampled on the clk rising edge.
REQ-006 The block SHALL have port bin_in, input, BIN_WIDTH bits, unsigned value to convert, sampled only on the cycle start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, single-cycle pulse marking a new result.
REQ-009 The block SHALL have port bcd_out, output, 4*DIGITS bits, packed result; digit 0 (least significant) in bits [3:0], one nibble per downstream 7-segment decoder.
REQ-010 The block SHALL have port overflow, output, 1 bit, high when the last result exceeded DIGITS decimal digits.
REQ-011 The block SHALL have port blank_out, output, DIGITS bits, per-digit leading-zero blank flag; bit i belongs to digit i.

Function
REQ-012 The block SHALL implement sequential shift-add-3 (double dabble) conversion, one input bit per clock.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE; reset enters IDLE.
REQ-014 In IDLE, start=1 SHALL load bin_in into a shift register, clear the BCD scratch register and the bit counter, and move to SHIFT.
REQ-015 In SHIFT, each cycle SHALL first add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit.
REQ-016 SHIFT SHALL last exactly BIN_WIDTH cycles and then move to DONE.
REQ-017 In DONE, bcd_out, overflow and blank_out SHALL update from the scratch register, done SHALL be 1 for that cycle only, and the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be BIN_WIDTH+1 cycles: done is high on the (BIN_WIDTH+1)th rising edge after the edge that accepted start.
REQ-019 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1; no queuing, and no effect on the running conversion.
REQ-021 Back-to-back conversions SHALL be possible: start held high is accepted again on the first IDLE cycle after DONE.
REQ-022 A 1 shifted out of the top scratch digit SHALL set a sticky per-conversion overflow flag.
REQ-023 When overflow is set, bcd_out SHALL saturate to all digits 9.
REQ-024 bcd_out, overflow and blank_out SHALL hold their last values between done pulses.

Reset
REQ-025 Asserting reset at any time, mid-conversion included, SHALL immediately force state IDLE, busy=0, done=0, bcd_out=0, overflow=0 and blank_out=0, and discard any partial result.
REQ-026 After reset deasserts, the first rising edge with start=1 SHALL begin a new conversion.

Configuration
REQ-027 With macro BIN_TO_BCD_BLANK_EN defined, blank_out[i] SHALL be 1 when digit i and all higher digits are 0, for i >= 1; blank_out[0] is always 0, so value 0 shows a single "0".
REQ-028 Without BIN_TO_BCD_BLANK_EN, blank_out SHALL be tied to all zeros and no blanking logic SHALL be synthesized.
REQ-029 With overflow set, blank_out SHALL be all zeros in both configurations.

Verification
REQ-030 Defaults, bin_in=0, start pulse -> done exactly 25 cycles later, bcd_out=32'h00000000, overflow=0.
REQ-031 Defaults, bin_in=12345678 then 16777215, back to back -> bcd_out=32'h12345678 then 32'h16777215, each done pulse 1 cycle wide, busy low for exactly 1 cycle between.
REQ-032 start re-pulsed at cycle 10 of a conversion of 999 with bin_in=5 -> result 32'h00000999; no extra done pulse.
REQ-033 reset asserted at cycle 12 of a conversion -> outputs 0 at once, no done pulse; the next conversion of 42 gives 32'h00000042.
REQ-034 BIN_WIDTH=8, DIGITS=2, bin_in=255 -> bcd_out=8'h99, overflow=1; then bin_in=99 -> 8'h99, overflow=0.
REQ-035 With BIN_TO_BCD_BLANK_EN, bin_in=405 -> blank_out=8'b11111000; bin_in=0 -> 8'b11111110. Without the macro, both give 8'b00000000.
